// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobe walk, column debounce,
// one hex key code per press delivered over a valid/ack handshake.
module keypad_scanner #(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] rows,
    input  logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_e;

    logic [SCAN_DIV_BITS-1:0] presc_q;
    logic [3:0]  rows_q, rows_d;
    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]  col_q, col_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        tick, hit, accept;
    logic [1:0]  col_idx, row_idx;

    assign tick    = &presc_q;
    assign hit     = ~&cols;
    assign cnt_inc = cnt_q + CW'(1);

    // Lowest-numbered pressed column wins
    always_comb begin
        col_idx = 2'd3;
        if (!cols[0])      col_idx = 2'd0;
        else if (!cols[1]) col_idx = 2'd1;
        else if (!cols[2]) col_idx = 2'd2;
    end

    always_comb begin
        case (rows_q)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        accept  = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (hit) begin
                        col_d   = col_idx;
                        cnt_d   = CW'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        rows_d = {rows_q[2:0], rows_q[3]};
                    end
                end
                DEBOUNCE: begin
                    if (hit && col_idx == col_q) begin
                        if (cnt_inc == CNT_MAX) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (hit) begin
                        cnt_d = '0;
                    end else if (cnt_inc == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    // A same-cycle ack makes room for the new key, so no overrun then
    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (accept) begin
            code_d  = {row_idx, col_q};
            valid_d = 1'b1;
            if (valid_q && !key_ack) ovr_d = 1'b1;
        end else if (valid_q && key_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            rows_q  <= 4'b1110;
            state_q <= SCAN;
            cnt_q   <= '0;
            col_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            presc_q <= presc_q + SCAN_DIV_BITS'(1);
            rows_q  <= rows_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rows      = rows_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios then random presses,
// all outputs compared every cycle against a keypad-level model.
module tb_keypad_scanner;

    localparam int DS = 3;
    localparam int MS_SCAN = 0;
    localparam int MS_DEB  = 1;
    localparam int MS_HELD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols = 4'hF;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack = 1'b0;
    logic       overrun;

    keypad_scanner #(.SCAN_DIV_BITS(2), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst(rst), .rows(rows), .cols(cols),
        .key_code(key_code), .key_valid(key_valid),
        .key_ack(key_ack), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // model of the keypad and of the scanner's observable behaviour
    logic [15:0] pressed = '0;
    int   m_cyc, m_r, m_mode, m_run, m_col;
    logic [3:0] m_code;
    bit   m_valid, m_ovr;
    bit   ack_on_accept = 0;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_r = 0; m_mode = MS_SCAN; m_run = 0; m_col = 0;
        m_code = 4'h0; m_valid = 0; m_ovr = 0;
    endtask

    function automatic int low_col(input logic [3:0] c);
        int r = 0;
        for (int i = 3; i >= 0; i--) if (!c[i]) r = i;
        return r;
    endfunction

    function automatic logic [3:0] calc_cols();
        logic [3:0] c = 4'hF;
        for (int k = 0; k < 4; k++) if (pressed[m_r*4+k]) c[k] = 1'b0;
        return c;
    endfunction

    function automatic bit will_accept(input logic [3:0] c);
        return (m_cyc == 3) && (m_mode == MS_DEB) && (c != 4'hF)
            && (low_col(c) == m_col) && (m_run == DS - 1);
    endfunction

    task automatic model_step(input logic [3:0] c, input logic a);
        bit tk, h, acc;
        int lc;
        tk = (m_cyc == 3);
        m_cyc = (m_cyc + 1) % 4;
        h = (c != 4'hF);
        lc = low_col(c);
        acc = 0;
        if (tk) begin
            if (m_mode == MS_SCAN) begin
                if (h) begin m_col = lc; m_run = 1; m_mode = MS_DEB; end
                else m_r = (m_r + 1) % 4;
            end else if (m_mode == MS_DEB) begin
                if (h && lc == m_col) begin
                    m_run++;
                    if (m_run == DS) begin acc = 1; m_run = 0; m_mode = MS_HELD; end
                end else begin
                    m_run = 0; m_mode = MS_SCAN;
                end
            end else begin
                if (h) m_run = 0;
                else begin
                    m_run++;
                    if (m_run == DS) begin m_run = 0; m_mode = MS_SCAN; end
                end
            end
        end
        if (acc) begin
            if (m_valid && !a) m_ovr = 1;
            m_code = 4'(m_r * 4 + m_col);
            m_valid = 1;
        end else if (m_valid && a) begin
            m_valid = 0; m_ovr = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] er;
        er = 4'hF ^ (4'h1 << m_r);
        check(tag, {6'd0, rows, key_code, key_valid, overrun},
              {6'd0, er, m_code, m_valid, m_ovr});
    endtask

    task automatic cyc(input logic a);
        logic [3:0] c;
        @(negedge clk);
        c = calc_cols();
        cols = c;
        key_ack = a | (ack_on_accept && will_accept(c));
        @(posedge clk);
        if (!rst) model_step(c, key_ack);
        #1;
        check_all("cycle");
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200 && key_valid !== 1'b1; i++) cyc(1'b0);
        check(tag, 16'(key_valid), 16'd1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_now", {8'd0, rows, key_code}, {8'd0, 4'hE, 4'h0});
        check("rst_flags", {14'd0, key_valid, overrun}, 16'd0);
        repeat (4) cyc(1'b0);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) cyc(1'b0);
        check("reset_rows", 16'(rows), 16'hE);
        check("reset_flags", {10'd0, key_code, key_valid, overrun}, 16'd0);
        rst = 1'b0;

        // idle rotation
        repeat (40) cyc(1'b0);
        check("idle_valid", 16'(key_valid), 16'd0);

        // single press of key 6, then long hold and release
        pressed[6] = 1'b1;
        wait_valid("k6_valid");
        check("k6_code", 16'(key_code), 16'h6);
        repeat (8) cyc(1'b0);
        check("k6_hold_valid", 16'(key_valid), 16'd1);
        cyc(1'b1);
        check("k6_acked", 16'(key_valid), 16'd0);
        repeat (80) cyc(1'b0);
        check("k6_norepeat", 16'(key_valid), 16'd0);
        pressed = '0;
        repeat (16) cyc(1'b0);

        // bouncing key 0 must not be accepted
        for (int t = 0; t < 12; t++) begin
            pressed[0] = (t % 2 == 0);
            repeat (4) cyc(1'b0);
        end
        check("bounce_valid", 16'(key_valid), 16'd0);
        pressed[0] = 1'b1;
        repeat (40) cyc(1'b0);
        check("k0_code", {11'd0, key_code, key_valid}, {11'd0, 4'h0, 1'b1});
        pressed = '0;
        repeat (16) cyc(1'b0);
        cyc(1'b1);
        pressed[13] = 1'b1;
        pressed[15] = 1'b1;
        wait_valid("kD_valid");
        check("kD_code", 16'(key_code), 16'hD);
        pressed = '0;
        repeat (16) cyc(1'b0);
        cyc(1'b1);

        // overrun on two unacked presses
        pressed[5] = 1'b1;
        wait_valid("k5_valid");
        pressed = '0;
        repeat (16) cyc(1'b0);
        pressed[10] = 1'b1;
        repeat (40) cyc(1'b0);
        check("ovr_code", {11'd0, key_code, overrun}, {11'd0, 4'hA, 1'b1});
        pressed = '0;
        repeat (16) cyc(1'b0);
        cyc(1'b1);
        check("ovr_cleared", {14'd0, key_valid, overrun}, 16'd0);

        // ack on the exact accept cycle of a second key
        pressed[3] = 1'b1;
        wait_valid("k3_valid");
        pressed = '0;
        repeat (16) cyc(1'b0);
        ack_on_accept = 1;
        pressed[9] = 1'b1;
        repeat (40) cyc(1'b0);
        ack_on_accept = 0;
        check("ackacc", {10'd0, key_code, key_valid, overrun},
              {10'd0, 4'h9, 1'b1, 1'b0});
        pressed = '0;
        repeat (16) cyc(1'b0);
        cyc(1'b1);

        // reset while held, key re-reported
        pressed[6] = 1'b1;
        wait_valid("held_valid");
        repeat (4) cyc(1'b0);
        async_reset();
        repeat (60) cyc(1'b0);
        check("held_rerep", {11'd0, key_code, key_valid}, {11'd0, 4'h6, 1'b1});
        pressed = '0;
        repeat (16) cyc(1'b0);
        cyc(1'b1);

        // reset mid-debounce
        pressed[6] = 1'b1;
        for (int i = 0; i < 200 && m_mode != MS_DEB; i++) cyc(1'b0);
        if (m_mode != MS_DEB) begin
            checks++;
            errs++;
            $error("FAIL deb_wait observed=timeout expected=debounce");
        end
        async_reset();
        repeat (60) cyc(1'b0);
        check("deb_rerep", {11'd0, key_code, key_valid}, {11'd0, 4'h6, 1'b1});
        pressed = '0;
        repeat (16) cyc(1'b0);
        cyc(1'b1);

        // random presses and acks
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 2) == 0) pressed = '0;
                else pressed = 16'h1 << $urandom_range(0, 15);
            end
            cyc(1'($urandom_range(0, 5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
